// File: rtl/glyph_stroke_drawer_pkg.sv
// Shared types and tables for the stroke-font glyph drawer: FSM states,
// stroke identifiers and the per-letter stroke masks.
package morse_draw_pkg;

    localparam int GLYPH_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STROKE,
        ST_FIN
    } state_t;

    localparam logic [2:0] STK_TOP = 3'd0;
    localparam logic [2:0] STK_MID = 3'd1;
    localparam logic [2:0] STK_BOT = 3'd2;
    localparam logic [2:0] STK_UL  = 3'd3;
    localparam logic [2:0] STK_LL  = 3'd4;
    localparam logic [2:0] STK_UR  = 3'd5;
    localparam logic [2:0] STK_LR  = 3'd6;

    // Bit n set means stroke n is drawn; entries 26..31 render as blank cells.
    localparam logic [6:0] GLYPH_MASK [0:31] = '{
        7'b1111011, 7'b1111111, 7'b0011101, 7'b1111101, 7'b0011111, // A B C D E
        7'b0011011, 7'b1011101, 7'b1111010, 7'b0000101, 7'b1110100, // F G H I J
        7'b1011010, 7'b0011100, 7'b1111001, 7'b1111000, 7'b1111101, // K L M N O
        7'b0111011, 7'b1101011, 7'b1011011, 7'b1001111, 7'b0000001, // P Q R S T
        7'b1111100, 7'b1010100, 7'b1111110, 7'b1111010, 7'b1101110, // U V W X Y
        7'b0110111,                                                 // Z
        7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000
    };

    function automatic logic [2:0] lowest_stroke(input logic [6:0] m);
        lowest_stroke = 3'd0;
        for (int k = 6; k >= 0; k--) begin
            if (m[k]) lowest_stroke = 3'(k);
        end
    endfunction

endpackage

// File: rtl/glyph_stroke_drawer_if.sv
// Request/pixel bundle between the decoder FSM (master) and the glyph drawer (slave).
interface glyph_stroke_drawer_if
    import morse_draw_pkg::*;
#(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3
);
    logic                start;
    logic [GLYPH_W-1:0]  glyph;
    logic                erase;
    logic [X_W-1:0]      origin_x;
    logic [Y_W-1:0]      origin_y;
    logic [COLOUR_W-1:0] colour;
    logic [X_W-1:0]      out_x;
    logic [Y_W-1:0]      out_y;
    logic [COLOUR_W-1:0] out_colour;
    logic                plot;
    logic                busy;
    logic                done;

    modport master (
        output start, glyph, erase, origin_x, origin_y, colour,
        input  out_x, out_y, out_colour, plot, busy, done
    );

    modport slave (
        input  start, glyph, erase, origin_x, origin_y, colour,
        output out_x, out_y, out_colour, plot, busy, done
    );
endinterface

// File: rtl/glyph_stroke_drawer_stroke_walker.sv
// Pure geometry: maps (stroke id, pixel index, origin) to a screen pixel and
// flags the final pixel of that stroke. Coordinates wrap at the bus widths.
module stroke_walker
    import morse_draw_pkg::*;
#(
    parameter int X_W  = 8,
    parameter int Y_W  = 7,
    parameter int SIZE = 32,
    parameter int IW   = $clog2(SIZE)
) (
    input  logic [2:0]     sid_i,
    input  logic [IW-1:0]  idx_i,
    input  logic [X_W-1:0] ox_i,
    input  logic [Y_W-1:0] oy_i,
    output logic [X_W-1:0] x_o,
    output logic [Y_W-1:0] y_o,
    output logic           last_o
);
    localparam int             HALF   = SIZE / 2;
    localparam logic [X_W-1:0] XLAST  = X_W'(SIZE - 1);
    localparam logic [Y_W-1:0] YHALF  = Y_W'(HALF);
    localparam logic [Y_W-1:0] YLAST  = Y_W'(SIZE - 1);
    localparam logic [IW-1:0]  ILONG  = IW'(SIZE - 1);
    localparam logic [IW-1:0]  ISHORT = IW'(HALF - 1);

    logic [X_W-1:0] ix;
    logic [Y_W-1:0] iy;

    assign ix = X_W'(idx_i);
    assign iy = Y_W'(idx_i);

    // Horizontal strokes span the full cell width, vertical ones half the height.
    always_comb begin
        x_o    = ox_i;
        y_o    = oy_i;
        last_o = (idx_i == ISHORT);
        case (sid_i)
            STK_TOP: begin x_o = ox_i + ix;                          last_o = (idx_i == ILONG); end
            STK_MID: begin x_o = ox_i + ix; y_o = oy_i + YHALF;      last_o = (idx_i == ILONG); end
            STK_BOT: begin x_o = ox_i + ix; y_o = oy_i + YLAST;      last_o = (idx_i == ILONG); end
            STK_UL:  begin                  y_o = oy_i + iy;                                    end
            STK_LL:  begin                  y_o = oy_i + YHALF + iy;                            end
            STK_UR:  begin x_o = ox_i + XLAST; y_o = oy_i + iy;                                 end
            STK_LR:  begin x_o = ox_i + XLAST; y_o = oy_i + YHALF + iy;                         end
            default: ;
        endcase
    end
endmodule

// File: rtl/glyph_stroke_drawer.sv
// Stroke-font letter renderer: on start, walks the selected glyph's strokes and
// emits one registered pixel per clock, then pulses done.
module glyph_stroke_drawer
    import morse_draw_pkg::*;
#(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int SIZE     = 32,
    parameter int COLOUR_W = 3
) (
    input logic                  clk,
    input logic                  resetn,
    glyph_stroke_drawer_if.slave bus
);
    localparam int IW = $clog2(SIZE);

    state_t              state_q, state_d;
    logic [6:0]          mask_q, mask_d;
    logic [2:0]          sid_q, sid_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [GLYPH_W-1:0]  glyph_q, glyph_d;
    logic [X_W-1:0]      ox_q, ox_d;
    logic [Y_W-1:0]      oy_q, oy_d;
    logic [COLOUR_W-1:0] col_q, col_d;
    logic [X_W-1:0]      out_x_q, out_x_d;
    logic [Y_W-1:0]      out_y_q, out_y_d;
    logic [COLOUR_W-1:0] out_col_q, out_col_d;
    logic                plot_q, plot_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [6:0]          cur_mask, rest_mask;
    logic [2:0]          cur_sid;
    logic [IW-1:0]       cur_idx;
    logic                emit;
    logic [X_W-1:0]      w_x;
    logic [Y_W-1:0]      w_y;
    logic                w_last;

    stroke_walker #(.X_W(X_W), .Y_W(Y_W), .SIZE(SIZE), .IW(IW)) u_walker (
        .sid_i  (cur_sid),
        .idx_i  (cur_idx),
        .ox_i   (ox_q),
        .oy_i   (oy_q),
        .x_o    (w_x),
        .y_o    (w_y),
        .last_o (w_last)
    );

    // In LOAD the first pixel comes straight from the table so it is plotted on the next edge.
    always_comb begin
        cur_mask = mask_q;
        cur_sid  = sid_q;
        cur_idx  = idx_q;
        if (state_q == ST_LOAD) begin
            cur_mask = GLYPH_MASK[glyph_q];
            cur_sid  = lowest_stroke(cur_mask);
            cur_idx  = '0;
        end
        emit      = ((state_q == ST_LOAD) || (state_q == ST_STROKE)) && (cur_mask != '0);
        rest_mask = cur_mask & ~(7'b1 << cur_sid);
    end

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        sid_d     = sid_q;
        idx_d     = idx_q;
        glyph_d   = glyph_q;
        ox_d      = ox_q;
        oy_d      = oy_q;
        col_d     = col_q;
        out_x_d   = out_x_q;
        out_y_d   = out_y_q;
        out_col_d = out_col_q;
        plot_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    glyph_d = bus.glyph;
                    ox_d    = bus.origin_x;
                    oy_d    = bus.origin_y;
                    col_d   = bus.erase ? '0 : bus.colour;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD, ST_STROKE: begin
                if (emit) begin
                    out_x_d   = w_x;
                    out_y_d   = w_y;
                    out_col_d = col_q;
                    plot_d    = 1'b1;
                    state_d   = ST_STROKE;
                    // Hand over to the next stroke on the same edge as the last pixel.
                    if (w_last) begin
                        mask_d = rest_mask;
                        sid_d  = lowest_stroke(rest_mask);
                        idx_d  = '0;
                    end else begin
                        mask_d = cur_mask;
                        sid_d  = cur_sid;
                        idx_d  = cur_idx + IW'(1);
                    end
                end else begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_LOAD) || (state_d == ST_STROKE);
        done_d = (state_d == ST_FIN);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            mask_q    <= '0;
            sid_q     <= '0;
            idx_q     <= '0;
            glyph_q   <= '0;
            ox_q      <= '0;
            oy_q      <= '0;
            col_q     <= '0;
            out_x_q   <= '0;
            out_y_q   <= '0;
            out_col_q <= '0;
            plot_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            sid_q     <= sid_d;
            idx_q     <= idx_d;
            glyph_q   <= glyph_d;
            ox_q      <= ox_d;
            oy_q      <= oy_d;
            col_q     <= col_d;
            out_x_q   <= out_x_d;
            out_y_q   <= out_y_d;
            out_col_q <= out_col_d;
            plot_q    <= plot_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.out_x      = out_x_q;
    assign bus.out_y      = out_y_q;
    assign bus.out_colour = out_col_q;
    assign bus.plot       = plot_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_glyph_stroke_drawer.sv
// Bench for glyph_stroke_drawer: directed vector table, random draws against a
// stroke-list reference model, and hand-built reset / back-to-back sequences.
module tb_glyph_stroke_drawer;
    import morse_draw_pkg::*;

    localparam int X_W = 8, Y_W = 7, SIZE = 32, COLOUR_W = 3, HALF = SIZE / 2;

    logic clk = 1'b0;
    logic resetn = 1'b0;

    glyph_stroke_drawer_if #(.X_W(X_W), .Y_W(Y_W), .COLOUR_W(COLOUR_W)) bus_if ();

    glyph_stroke_drawer #(.X_W(X_W), .Y_W(Y_W), .SIZE(SIZE), .COLOUR_W(COLOUR_W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_if)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference pixel list and observed stream of the current draw.
    int mx[$], my[$];
    int px[$], py[$], pc[$], pcyc[$];
    int done_cyc, done_cnt, busy_err;

    typedef struct {
        logic [4:0] g;
        logic       e;
        int         ox, oy, col;
        int         n, fx, fy, lx, ly, ecol, dcyc;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    // Pixels in stroke-bit order, each stroke walked from its start point.
    function automatic void build_model(input logic [4:0] g, input int ox, input int oy);
        logic [6:0] m;
        int len, x, y;
        mx.delete();
        my.delete();
        m = GLYPH_MASK[g];
        for (int b = 0; b < 7; b++) begin
            if (m[b]) begin
                len = (b < 3) ? SIZE : HALF;
                for (int i = 0; i < len; i++) begin
                    case (b)
                        0:       begin x = ox + i;        y = oy;            end
                        1:       begin x = ox + i;        y = oy + HALF;     end
                        2:       begin x = ox + i;        y = oy + SIZE - 1; end
                        3:       begin x = ox;            y = oy + i;        end
                        4:       begin x = ox;            y = oy + HALF + i; end
                        5:       begin x = ox + SIZE - 1; y = oy + i;        end
                        default: begin x = ox + SIZE - 1; y = oy + HALF + i; end
                    endcase
                    mx.push_back(x % 256);
                    my.push_back(y % 128);
                end
            end
        end
    endfunction

    // Cycle k is the observation #1 after the k-th edge, edge 1 being the one that accepts start.
    task automatic run_draw(input logic [4:0] g, input logic e, input int ox, input int oy,
                            input int c, input int pulse_at);
        int n, limit;
        build_model(g, ox, oy);
        n = mx.size();
        limit = n + 8;
        px.delete(); py.delete(); pc.delete(); pcyc.delete();
        done_cyc = -1; done_cnt = 0; busy_err = 0;
        @(negedge clk);
        bus_if.glyph    = g;
        bus_if.erase    = e;
        bus_if.origin_x = 8'(ox);
        bus_if.origin_y = 7'(oy);
        bus_if.colour   = 3'(c);
        bus_if.start    = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 1; k <= limit; k++) begin
            if (k > 1) begin
                @(posedge clk);
                #1;
            end
            if (k == 1) begin
                bus_if.glyph    = 5'($urandom_range(0, 31));
                bus_if.erase    = 1'($urandom_range(0, 1));
                bus_if.origin_x = 8'($urandom_range(0, 255));
                bus_if.origin_y = 7'($urandom_range(0, 127));
                bus_if.colour   = 3'($urandom_range(0, 7));
            end
            bus_if.start = ((k + 1) == pulse_at);
            if (bus_if.plot) begin
                px.push_back(int'(bus_if.out_x));
                py.push_back(int'(bus_if.out_y));
                pc.push_back(int'(bus_if.out_colour));
                pcyc.push_back(k);
            end
            if (bus_if.done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = k;
            end
            if (bus_if.busy !== (k <= n + 1)) busy_err++;
        end
        bus_if.start = 1'b0;
    endtask

    task automatic verify_draw(input string nm, input int ecol);
        int n, seq_err;
        n = mx.size();
        seq_err = 0;
        for (int i = 0; i < px.size() && i < n; i++) begin
            if (px[i] != mx[i] || py[i] != my[i] || pc[i] != ecol || pcyc[i] != i + 2) seq_err++;
        end
        check({nm, " plot count"}, px.size(), n);
        check({nm, " pixel seq errors"}, seq_err, 0);
        check({nm, " done cycle"}, done_cyc, n + 2);
        check({nm, " done pulses"}, done_cnt, 1);
        check({nm, " busy errors"}, busy_err, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, cnt2;
        logic [5:0] busy_bits, done_bits;
        logic [4:0] rg;
        logic       re;
        int         rox, roy, rc;

        //          g   e  ox   oy  col   n   fx   fy   lx   ly  ecol dcyc
        tbl[0] = '{5'd4,  1'b0,  58, 29, 7, 128,  58,  29,  58,  60, 7, 130};
        tbl[1] = '{5'd31, 1'b0,  12, 12, 4,   0,   0,   0,   0,   0, 4,   2};
        tbl[2] = '{5'd19, 1'b0, 240, 10, 3,  32, 240,  10,  15,  10, 3,  34};
        tbl[3] = '{5'd4,  1'b1,  58, 29, 5, 128,  58,  29,  58,  60, 0, 130};
        tbl[4] = '{5'd1,  1'b0,   0,  0, 6, 160,   0,   0,  31,  31, 6, 162};
        tbl[5] = '{5'd11, 1'b0,  10,100, 2,  64,  10,   3,  10,   3, 2,  66};
        tbl[6] = '{5'd26, 1'b0,  80, 60, 1,   0,   0,   0,   0,   0, 1,   2};
        tbl[7] = '{5'd8,  1'b0, 100, 50, 7,  64, 100,  50, 131 % 256, 81, 7, 66};

        bus_if.start = 1'b0; bus_if.glyph = '0; bus_if.erase = 1'b0;
        bus_if.origin_x = '0; bus_if.origin_y = '0; bus_if.colour = '0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        check("reset plot", int'(bus_if.plot), 0);
        check("reset busy", int'(bus_if.busy), 0);
        check("reset done", int'(bus_if.done), 0);
        check("reset out_x", int'(bus_if.out_x), 0);
        check("reset out_y", int'(bus_if.out_y), 0);
        check("reset out_colour", int'(bus_if.out_colour), 0);

        for (int v = 0; v < 8; v++) begin
            run_draw(tbl[v].g, tbl[v].e, tbl[v].ox, tbl[v].oy, tbl[v].col, 0);
            verify_draw($sformatf("vec%0d", v), tbl[v].ecol);
            check($sformatf("vec%0d plots", v), px.size(), tbl[v].n);
            check($sformatf("vec%0d done cycle", v), done_cyc, tbl[v].dcyc);
            if (tbl[v].n > 0) begin
                check($sformatf("vec%0d first x", v), (px.size() > 0) ? px[0] : -1, tbl[v].fx);
                check($sformatf("vec%0d first y", v), (py.size() > 0) ? py[0] : -1, tbl[v].fy);
                check($sformatf("vec%0d last x", v), (px.size() > 0) ? px[px.size()-1] : -1, tbl[v].lx);
                check($sformatf("vec%0d last y", v), (py.size() > 0) ? py[py.size()-1] : -1, tbl[v].ly);
                check($sformatf("vec%0d colour", v), (pc.size() > 0) ? pc[0] : -1, tbl[v].ecol);
            end
        end

        for (int r = 0; r < 20; r++) begin
            rg  = 5'($urandom_range(0, 31));
            re  = 1'($urandom_range(0, 1));
            rox = $urandom_range(0, 255);
            roy = $urandom_range(0, 127);
            rc  = $urandom_range(0, 7);
            run_draw(rg, re, rox, roy, rc, 0);
            verify_draw($sformatf("rnd%0d g=%0d", r, rg), re ? 0 : rc);
        end

        // Stray start mid-draw must not queue a second draw.
        run_draw(5'd4, 1'b0, 58, 29, 7, 10);
        verify_draw("start during busy", 7);

        // Reset asserted mid-draw: outputs clear without a clock and no done follows.
        @(negedge clk);
        bus_if.glyph = 5'd4; bus_if.erase = 1'b0; bus_if.origin_x = 8'd58;
        bus_if.origin_y = 7'd29; bus_if.colour = 3'd7; bus_if.start = 1'b1;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        cnt = 0; cnt2 = 0;
        for (int k = 2; k <= 39; k++) begin
            @(posedge clk);
            #1;
            if (bus_if.plot) cnt++;
            if (bus_if.done) cnt2++;
        end
        #2 resetn = 1'b0;
        #1;
        check("abort plot", int'(bus_if.plot), 0);
        check("abort busy", int'(bus_if.busy), 0);
        check("abort done", int'(bus_if.done), 0);
        check("abort out_x", int'(bus_if.out_x), 0);
        check("abort out_y", int'(bus_if.out_y), 0);
        check("abort plots before reset", cnt, 38);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (bus_if.done || bus_if.busy || bus_if.plot) cnt2++;
        end
        check("abort no activity", cnt2, 0);
        run_draw(5'd4, 1'b0, 58, 29, 7, 0);
        verify_draw("after abort", 7);

        // Start held high: next draw is taken on the first IDLE cycle after FIN.
        @(negedge clk);
        bus_if.glyph = 5'd31; bus_if.start = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            busy_bits[k] = bus_if.busy;
            done_bits[k] = bus_if.done;
        end
        bus_if.start = 1'b0;
        check("b2b busy pattern", int'(busy_bits), int'(6'b001001));
        check("b2b done pattern", int'(done_bits), int'(6'b010010));
        repeat (4) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
